fix_chk_ctrl: RTL

Sequencer for FIX checksum verification on the inbound byte stream. It frames each message from "8=" to the trailing "10=NNN<SOH>" and drives a running mod-256 byte-sum accumulator. It snapshots the sum at every SOH so that the snapshot preceding the trailer is the computed checksum. It then parses the 3 ASCII digits, compares them and holds a verdict until the downstream parser acknowledges it.

---
 rtl/fix_pkg.sv | 19 +
 rtl/fix_sum_accum.sv | 25 ++
 rtl/fix_chk_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fix_pkg.sv
// Shared state encoding and ASCII constants for the FIX checksum sequencer.
package fix_pkg;

  typedef enum logic [3:0] {
    IDLE, START_EQ, BODY, TAG1, TAG0, TAG_EQ, DIG, TERM, REPORT
  } chk_state_t;

  localparam logic [7:0] ASC_8   = 8'h38;
  localparam logic [7:0] ASC_EQ  = 8'h3D;
  localparam logic [7:0] ASC_1   = 8'h31;
  localparam logic [7:0] ASC_0   = 8'h30;
  localparam logic [7:0] ASC_9   = 8'h39;
  localparam logic [7:0] SOH_DEF = 8'h01;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASC_0) && (b <= ASC_9);
  endfunction

endpackage

// File: rtl/fix_sum_accum.sv
// Mod-256 running byte sum with a snapshot register loaded at field delimiters.
module fix_sum_accum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       snap_en,
  input  logic [7:0] data,
  output logic [7:0] sum,
  output logic [7:0] snap
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      snap <= '0;
    end else begin
      // clr together with en starts a fresh sum at the current byte
      if (clr)     sum <= en ? data : 8'h00;
      else if (en) sum <= sum + data;
      if (snap_en) snap <= sum + data;
    end
  end

endmodule

// File: rtl/fix_chk_ctrl.sv
// Frames FIX messages, tracks the trailer checksum and holds a verdict until acknowledged.
module fix_chk_ctrl
  import fix_pkg::*;
#(
  parameter int         MAX_LEN = 4096,
  parameter logic [7:0] SOH     = SOH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       ack_i,
  output logic       chk_valid_o,
  output logic       chk_ok_o,
  output logic       err_fmt_o,
  output logic       err_len_o,
  output logic [7:0] chk_calc_o,
  output logic [9:0] chk_recv_o,
  output logic       in_msg_o
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);

  // Handshake: a byte transfers on a clock edge where valid_i && ready_o;
  // ready_o is low only while a verdict is held, so input stalls then.
  chk_state_t    state;
  logic [LW-1:0] len;
  logic [1:0]    dcnt;
  logic [7:0]    sum, snap;
  logic          accept, sum_state, len_full;
  logic          acc_clr, acc_en, snap_en;
  logic [9:0]    recv_nxt;

  assign accept    = valid_i && ready_o;
  assign sum_state = state inside {START_EQ, BODY, TAG1, TAG0, TAG_EQ};
  assign len_full  = (len == MAX_L);
  assign recv_nxt  = chk_recv_o * 10'd10 + 10'(data_i[3:0]);

  always_comb begin
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    snap_en = 1'b0;
    if (accept) begin
      if (state == IDLE) begin
        acc_clr = (data_i == ASC_8);
        acc_en  = (data_i == ASC_8);
      end else if (state == START_EQ) begin
        acc_clr = (data_i != ASC_EQ);
        acc_en  = (data_i == ASC_EQ) || (data_i == ASC_8);
      end else if (state inside {BODY, TAG1, TAG0}) begin
        acc_en = 1'b1;
      end else if (state == TAG_EQ) begin
        acc_en = (data_i != ASC_EQ);
      end
      snap_en = sum_state && (data_i == SOH);
    end
  end

  fix_sum_accum u_sum (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .en      (acc_en),
    .snap_en (snap_en),
    .data    (data_i),
    .sum     (sum),
    .snap    (snap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len         <= '0;
      dcnt        <= '0;
      ready_o     <= 1'b1;
      chk_valid_o <= 1'b0;
      chk_ok_o    <= 1'b0;
      err_fmt_o   <= 1'b0;
      err_len_o   <= 1'b0;
      chk_calc_o  <= '0;
      chk_recv_o  <= '0;
      in_msg_o    <= 1'b0;
    end else if (state == REPORT) begin
      if (ack_i) begin
        state       <= IDLE;
        ready_o     <= 1'b1;
        chk_valid_o <= 1'b0;
        chk_ok_o    <= 1'b0;
        err_fmt_o   <= 1'b0;
        err_len_o   <= 1'b0;
      end
    end else if (accept) begin
      if (state != IDLE && len_full) begin
        state       <= REPORT;
        ready_o     <= 1'b0;
        chk_valid_o <= 1'b1;
        chk_ok_o    <= 1'b0;
        err_len_o   <= 1'b1;
        in_msg_o    <= 1'b0;
      end else begin
        if (state != IDLE) len <= len + 1'b1;
        case (state)
          IDLE: if (data_i == ASC_8) begin
            state    <= START_EQ;
            len      <= LW'(1);
            in_msg_o <= 1'b1;
          end
          START_EQ: begin
            if (data_i == ASC_EQ) state <= BODY;
            else if (data_i == ASC_8) len <= LW'(1);
            else begin
              state    <= IDLE;
              in_msg_o <= 1'b0;
            end
          end
          BODY: if (data_i == SOH) state <= TAG1;
          TAG1: begin
            if (data_i == ASC_1)    state <= TAG0;
            else if (data_i == SOH) state <= TAG1;
            else                    state <= BODY;
          end
          TAG0: begin
            if (data_i == ASC_0)    state <= TAG_EQ;
            else if (data_i == SOH) state <= TAG1;
            else                    state <= BODY;
          end
          TAG_EQ: begin
            if (data_i == ASC_EQ) begin
              state      <= DIG;
              chk_calc_o <= snap;
              chk_recv_o <= '0;
              dcnt       <= '0;
            end else if (data_i == SOH) state <= TAG1;
            else                        state <= BODY;
          end
          DIG: begin
            if (is_digit(data_i)) begin
              chk_recv_o <= recv_nxt;
              dcnt       <= dcnt + 2'd1;
              if (dcnt == 2'd2) state <= TERM;
            end else begin
              state       <= REPORT;
              ready_o     <= 1'b0;
              chk_valid_o <= 1'b1;
              chk_ok_o    <= 1'b0;
              err_fmt_o   <= 1'b1;
              in_msg_o    <= 1'b0;
            end
          end
          TERM: begin
            state       <= REPORT;
            ready_o     <= 1'b0;
            chk_valid_o <= 1'b1;
            chk_ok_o    <= (data_i == SOH) && (chk_recv_o == {2'b00, chk_calc_o});
            err_fmt_o   <= (data_i != SOH);
            in_msg_o    <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
